// File: rtl/key_event_pkg.sv
// Shared types and timing defaults for the DE2 pushbutton event generator.
// Optional auto-repeat is enabled by defining KEY_AUTO_REPEAT_EN.
package key_event_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_DB   = 2'd1,
    HELD       = 2'd2,
    RELEASE_DB = 2'd3
  } key_state_t;

  // Default timing in 50 MHz cycles: 10 ms debounce, 0.5 s hold, 0.1 s repeat.
  localparam int DEF_NUM_KEYS        = 3;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_HOLD_CYCLES     = 25000000;
  localparam int DEF_REPEAT_CYCLES   = 5000000;

  // Bits needed to count 0..n-1, never less than one.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/key_event_gen_key_channel.sv
// One key: two-flop synchroniser, debounce FSM, press/release/repeat pulses.
// Auto-repeat counter and phase flag exist only when KEY_AUTO_REPEAT_EN is defined.
module key_channel
  import key_event_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_n,
  output logic       pressed,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       repeat_pulse,
  output key_state_t state
);

  localparam int DB_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

  logic            sync1;
  logic            sync2;
  logic            key_s;
  logic [DB_W-1:0] db_cnt;

  assign key_s = sync2;

`ifdef KEY_AUTO_REPEAT_EN
  localparam int REP_W = cnt_width((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
  localparam logic [REP_W-1:0] HOLD_LAST = REP_W'(HOLD_CYCLES - 1);
  localparam logic [REP_W-1:0] REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep_cnt;
  logic             rep_phase;
  logic             rep_hit;

  // First repeat waits the long hold time, later ones the short period.
  assign rep_hit = rep_phase ? (rep_cnt == REP_LAST) : (rep_cnt == HOLD_LAST);
`else
  assign repeat_pulse = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1         <= 1'b0;
      sync2         <= 1'b0;
      state         <= IDLE;
      db_cnt        <= '0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
      rep_cnt       <= '0;
      rep_phase     <= 1'b0;
      repeat_pulse  <= 1'b0;
`endif
    end else begin
      sync1         <= ~key_n;
      sync2         <= sync1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
`ifdef KEY_AUTO_REPEAT_EN
      repeat_pulse  <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (key_s) begin
            state  <= PRESS_DB;
            db_cnt <= '0;
          end
        end
        PRESS_DB: begin
          if (!key_s) begin
            state <= IDLE;
          end else if (db_cnt == DB_LAST) begin
            state       <= HELD;
            pressed     <= 1'b1;
            press_pulse <= 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
            rep_cnt     <= '0;
`endif
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        HELD: begin
          if (!key_s) begin
            state  <= RELEASE_DB;
            db_cnt <= '0;
          end else begin
`ifdef KEY_AUTO_REPEAT_EN
            if (rep_hit) begin
              repeat_pulse <= 1'b1;
              rep_cnt      <= '0;
              rep_phase    <= 1'b1;
            end else begin
              rep_cnt <= rep_cnt + REP_W'(1);
            end
`endif
          end
        end
        RELEASE_DB: begin
          // A bounce back to pressed resumes HELD with the repeat count intact.
          if (key_s) begin
            state <= HELD;
          end else if (db_cnt == DB_LAST) begin
            state         <= IDLE;
            pressed       <= 1'b0;
            release_pulse <= 1'b1;
`ifdef KEY_AUTO_REPEAT_EN
            rep_phase     <= 1'b0;
`endif
          end else begin
            db_cnt <= db_cnt + DB_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/key_event_gen.sv
// DE2 KEY conditioner: NUM_KEYS independent debounced channels with event pulses.
// Define KEY_AUTO_REPEAT_EN to enable hold-to-repeat on each key.
module key_event_gen
  import key_event_pkg::*;
#(
  parameter int NUM_KEYS        = DEF_NUM_KEYS,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic [NUM_KEYS-1:0]   key_n,
  output logic [NUM_KEYS-1:0]   pressed,
  output logic [NUM_KEYS-1:0]   press_pulse,
  output logic [NUM_KEYS-1:0]   release_pulse,
  output logic [NUM_KEYS-1:0]   repeat_pulse,
  output logic [NUM_KEYS-1:0]   inc_pulse,
  output logic [2*NUM_KEYS-1:0] chan_state
);

  for (genvar i = 0; i < NUM_KEYS; i++) begin : g_chan
    key_state_t st;

    key_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .HOLD_CYCLES     (HOLD_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_chan (
      .clk           (CLOCK_50),
      .reset         (reset),
      .key_n         (key_n[i]),
      .pressed       (pressed[i]),
      .press_pulse   (press_pulse[i]),
      .release_pulse (release_pulse[i]),
      .repeat_pulse  (repeat_pulse[i]),
      .state         (st)
    );

    assign chan_state[2*i +: 2] = st;
  end

  // repeat_pulse is constant 0 without auto-repeat, leaving inc_pulse = press_pulse.
  assign inc_pulse = press_pulse | repeat_pulse;

endmodule

// File: tb/tb_key_event_gen.sv
// Directed bench for key_event_gen with short debounce/hold/repeat timing.
// Repeat scenarios apply when KEY_AUTO_REPEAT_EN is defined, else the no-repeat check.
module tb_key_event_gen;

  localparam int NK = 3;

  logic          CLOCK_50 = 1'b0;
  logic          reset    = 1'b1;
  logic [NK-1:0] key_n    = '1;
  logic [NK-1:0] pressed, press_pulse, release_pulse, repeat_pulse, inc_pulse;
  logic [2*NK-1:0] chan_state;

  int tests_run = 0;
  int failures  = 0;

  key_event_gen #(
    .NUM_KEYS        (NK),
    .DEBOUNCE_CYCLES (4),
    .HOLD_CYCLES     (20),
    .REPEAT_CYCLES   (5)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .reset         (reset),
    .key_n         (key_n),
    .pressed       (pressed),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .repeat_pulse  (repeat_pulse),
    .inc_pulse     (inc_pulse),
    .chan_state    (chan_state)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  // Advance past one rising edge; outputs then reflect that edge.
  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    key_n = '1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    key_n = '1;
    tick();
    tick();
    tests_run++;
    if (pressed !== 3'b000) begin failures++; $display("FAIL reset_pressed got=%b exp=000", pressed); end
    tests_run++;
    if (press_pulse !== 3'b000) begin failures++; $display("FAIL reset_press got=%b exp=000", press_pulse); end
    tests_run++;
    if (release_pulse !== 3'b000) begin failures++; $display("FAIL reset_release got=%b exp=000", release_pulse); end
    tests_run++;
    if (repeat_pulse !== 3'b000) begin failures++; $display("FAIL reset_repeat got=%b exp=000", repeat_pulse); end
    tests_run++;
    if (inc_pulse !== 3'b000) begin failures++; $display("FAIL reset_inc got=%b exp=000", inc_pulse); end
    reset = 1'b0;
  endtask

  task automatic test_clean_press();
    do_reset();
    key_n = 3'b110;
    for (int e = 1; e <= 9; e++) begin
      tick();
      tests_run++;
      if (press_pulse[0] !== (e == 7)) begin
        failures++; $display("FAIL clean_press edge=%0d got=%b exp=%b", e, press_pulse[0], (e == 7));
      end
      tests_run++;
      if (pressed[0] !== (e >= 7)) begin
        failures++; $display("FAIL clean_pressed edge=%0d got=%b exp=%b", e, pressed[0], (e >= 7));
      end
      tests_run++;
      if (inc_pulse[0] !== (e == 7)) begin
        failures++; $display("FAIL clean_inc edge=%0d got=%b exp=%b", e, inc_pulse[0], (e == 7));
      end
      tests_run++;
      if (release_pulse !== 3'b000) begin
        failures++; $display("FAIL clean_release edge=%0d got=%b exp=000", e, release_pulse);
      end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    // Low on edges 1-2, high on edge 3, low from edge 4: window restarts, press at edge 10.
    for (int e = 1; e <= 12; e++) begin
      key_n = {1'b1, (e == 3), 1'b1};
      tick();
      tests_run++;
      if (press_pulse[1] !== (e == 10)) begin
        failures++; $display("FAIL bounce_press edge=%0d got=%b exp=%b", e, press_pulse[1], (e == 10));
      end
      tests_run++;
      if (pressed[1] !== (e >= 10)) begin
        failures++; $display("FAIL bounce_pressed edge=%0d got=%b exp=%b", e, pressed[1], (e >= 10));
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [NK-1:0] exp;
    do_reset();
    key_n = 3'b010;
    for (int e = 1; e <= 9; e++) begin
      tick();
      exp = (e == 7) ? 3'b101 : 3'b000;
      tests_run++;
      if (press_pulse !== exp) begin
        failures++; $display("FAIL simul_press edge=%0d got=%b exp=%b", e, press_pulse, exp);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    logic [NK-1:0] exp;
    do_reset();
    key_n = 3'b011;
    for (int e = 1; e <= 10; e++) tick();
    key_n = 3'b010;
    for (int e = 1; e <= 3; e++) tick();
    tests_run++;
    if (pressed !== 3'b100) begin failures++; $display("FAIL midrst_pre_pressed got=%b exp=100", pressed); end
    reset = 1'b1;
    tick();
    tests_run++;
    if (pressed !== 3'b000) begin failures++; $display("FAIL midrst_pressed got=%b exp=000", pressed); end
    tests_run++;
    if (press_pulse !== 3'b000) begin failures++; $display("FAIL midrst_press got=%b exp=000", press_pulse); end
    tests_run++;
    if (release_pulse !== 3'b000) begin failures++; $display("FAIL midrst_release got=%b exp=000", release_pulse); end
    tests_run++;
    if (repeat_pulse !== 3'b000) begin failures++; $display("FAIL midrst_repeat got=%b exp=000", repeat_pulse); end
    tests_run++;
    if (inc_pulse !== 3'b000) begin failures++; $display("FAIL midrst_inc got=%b exp=000", inc_pulse); end
    reset = 1'b0;
    for (int e = 1; e <= 9; e++) begin
      tick();
      exp = (e == 7) ? 3'b101 : 3'b000;
      tests_run++;
      if (press_pulse !== exp) begin
        failures++; $display("FAIL midrst_repress edge=%0d got=%b exp=%b", e, press_pulse, exp);
      end
    end
  endtask

`ifdef KEY_AUTO_REPEAT_EN
  task automatic test_auto_repeat();
    logic exp_rep;
    do_reset();
    key_n = 3'b110;
    for (int e = 1; e <= 60; e++) begin
      tick();
      exp_rep = (e >= 27) && (((e - 27) % 5) == 0);
      tests_run++;
      if (press_pulse[0] !== (e == 7)) begin
        failures++; $display("FAIL rep_press edge=%0d got=%b exp=%b", e, press_pulse[0], (e == 7));
      end
      tests_run++;
      if (repeat_pulse[0] !== exp_rep) begin
        failures++; $display("FAIL rep_repeat edge=%0d got=%b exp=%b", e, repeat_pulse[0], exp_rep);
      end
      tests_run++;
      if (inc_pulse[0] !== (exp_rep || (e == 7))) begin
        failures++; $display("FAIL rep_inc edge=%0d got=%b exp=%b", e, inc_pulse[0], (exp_rep || (e == 7)));
      end
    end
    // Released after edge 60: still HELD through edge 62 (repeat due), RELEASE_DB from 63.
    key_n = 3'b111;
    for (int e = 61; e <= 70; e++) begin
      tick();
      tests_run++;
      if (release_pulse[0] !== (e == 67)) begin
        failures++; $display("FAIL rel_pulse edge=%0d got=%b exp=%b", e, release_pulse[0], (e == 67));
      end
      tests_run++;
      if (repeat_pulse[0] !== (e == 62)) begin
        failures++; $display("FAIL rel_repeat edge=%0d got=%b exp=%b", e, repeat_pulse[0], (e == 62));
      end
      tests_run++;
      if (pressed[0] !== (e < 67)) begin
        failures++; $display("FAIL rel_pressed edge=%0d got=%b exp=%b", e, pressed[0], (e < 67));
      end
    end
  endtask

  task automatic test_release_glitch();
    do_reset();
    // One high sample at edge 12 holds rep_cnt for edges 14-15, moving repeats to 29 and 34.
    for (int e = 1; e <= 36; e++) begin
      key_n = {(e == 12), 2'b11};
      tick();
      tests_run++;
      if (press_pulse[2] !== (e == 7)) begin
        failures++; $display("FAIL glitch_press edge=%0d got=%b exp=%b", e, press_pulse[2], (e == 7));
      end
      tests_run++;
      if (release_pulse[2] !== 1'b0) begin
        failures++; $display("FAIL glitch_release edge=%0d got=%b exp=0", e, release_pulse[2]);
      end
      tests_run++;
      if (pressed[2] !== (e >= 7)) begin
        failures++; $display("FAIL glitch_pressed edge=%0d got=%b exp=%b", e, pressed[2], (e >= 7));
      end
      tests_run++;
      if (repeat_pulse[2] !== ((e == 29) || (e == 34))) begin
        failures++; $display("FAIL glitch_repeat edge=%0d got=%b exp=%b", e, repeat_pulse[2], ((e == 29) || (e == 34)));
      end
    end
  endtask
`else
  task automatic test_no_repeat();
    int presses;
    presses = 0;
    do_reset();
    key_n = 3'b110;
    for (int e = 1; e <= 60; e++) begin
      tick();
      if (press_pulse[0] === 1'b1) presses++;
      tests_run++;
      if (repeat_pulse !== 3'b000) begin
        failures++; $display("FAIL norep_repeat edge=%0d got=%b exp=000", e, repeat_pulse);
      end
      tests_run++;
      if (inc_pulse[0] !== (e == 7)) begin
        failures++; $display("FAIL norep_inc edge=%0d got=%b exp=%b", e, inc_pulse[0], (e == 7));
      end
    end
    tests_run++;
    if (presses != 1) begin failures++; $display("FAIL norep_count got=%0d exp=1", presses); end
  endtask
`endif

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_simultaneous();
    test_reset_mid_press();
`ifdef KEY_AUTO_REPEAT_EN
    test_auto_repeat();
    test_release_glitch();
`else
    test_no_repeat();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, failures);
    $finish;
  end

endmodule
